// File: rtl/fft_input_loader_if.sv
// Sample-stream and frame-output bundle for fft_input_loader.
//   s_valid/s_ready/s_real/s_imag/s_last : one complex sample per beat
//   dout_valid/dout_busy                 : whole-frame handoff to the butterfly stage
//   dout_real/dout_imag                  : N packed lanes, lane i at [i*WIDTH +: WIDTH]
//   frame_err                            : one-cycle pulse on s_last protocol violation
// master = producer/consumer side (drives samples and dout_busy); slave = loader.
interface fft_input_loader_if #(
    parameter int WIDTH  = 16,
    parameter int NPOINT = 3
);
    localparam int N = 2 ** NPOINT;

    logic                 s_valid;
    logic                 s_ready;
    logic [WIDTH-1:0]     s_real;
    logic [WIDTH-1:0]     s_imag;
    logic                 s_last;
    logic                 dout_valid;
    logic                 dout_busy;
    logic [WIDTH*N-1:0]   dout_real;
    logic [WIDTH*N-1:0]   dout_imag;
    logic                 frame_err;

    modport master (
        output s_valid, s_real, s_imag, s_last, dout_busy,
        input  s_ready, dout_valid, dout_real, dout_imag, frame_err
    );

    modport slave (
        input  s_valid, s_real, s_imag, s_last, dout_busy,
        output s_ready, dout_valid, dout_real, dout_imag, frame_err
    );
endinterface

// File: rtl/fft_input_loader.sv
// FFT input loader: collects one complex sample per beat into a ping-pong pair
// of N-lane banks, placing sample k in lane bitrev(k) (or k when BITREV=0), and
// presents each completed bank as one packed N-lane frame.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fft_input_loader_if.slave (sample stream in, frame out, frame_err)
module fft_input_loader #(
    parameter int WIDTH  = 16,
    parameter int NPOINT = 3,
    parameter int BITREV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_input_loader_if.slave    bus
);
    localparam int N = 2 ** NPOINT;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

    bank_state_t         bank_st     [2];
    bank_state_t         bank_st_nxt [2];
    logic                wr_ptr, wr_ptr_nxt;
    logic                rd_ptr, rd_ptr_nxt;
    logic [NPOINT-1:0]   cnt, cnt_nxt;
    logic                frame_err_q, frame_err_nxt;

    logic [WIDTH-1:0]    mem_re [2][N];
    logic [WIDTH-1:0]    mem_im [2][N];

    logic                s_ready_int;
    logic                dout_valid_int;
    logic                accept;
    logic                xfer;
    logic [NPOINT-1:0]   lane;

    function automatic logic [NPOINT-1:0] bitrev(input logic [NPOINT-1:0] v);
        logic [NPOINT-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NPOINT; i++) begin
            r[i] = v[NPOINT-1-i];
        end
        return r;
    endfunction

    assign s_ready_int    = !rst && (bank_st[wr_ptr] == EMPTY);
    assign dout_valid_int = (bank_st[rd_ptr] == FULL);
    assign accept         = bus.s_valid && s_ready_int;
    assign xfer           = dout_valid_int && !bus.dout_busy;
    assign lane           = (BITREV != 0) ? bitrev(cnt) : cnt;

    assign bus.s_ready    = s_ready_int;
    assign bus.dout_valid = dout_valid_int;
    assign bus.frame_err  = frame_err_q;

    // Accepting requires bank[wr_ptr] EMPTY and transferring requires
    // bank[rd_ptr] FULL, so a completion and a transfer in the same cycle
    // always touch different banks and can both be applied.
    always_comb begin
        bank_st_nxt[0] = bank_st[0];
        bank_st_nxt[1] = bank_st[1];
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        cnt_nxt        = cnt;
        frame_err_nxt  = 1'b0;

        if (xfer) begin
            bank_st_nxt[rd_ptr] = EMPTY;
            rd_ptr_nxt          = !rd_ptr;
        end

        if (accept) begin
            if (&cnt) begin
                bank_st_nxt[wr_ptr] = FULL;
                wr_ptr_nxt          = !wr_ptr;
                cnt_nxt             = '0;
                frame_err_nxt       = !bus.s_last;
            end else if (bus.s_last) begin
                // early s_last: drop the partial frame, bank stays EMPTY
                cnt_nxt       = '0;
                frame_err_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0]  <= EMPTY;
            bank_st[1]  <= EMPTY;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            cnt         <= '0;
            frame_err_q <= 1'b0;
        end else begin
            bank_st[0]  <= bank_st_nxt[0];
            bank_st[1]  <= bank_st_nxt[1];
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            cnt         <= cnt_nxt;
            frame_err_q <= frame_err_nxt;
        end
    end

    // Bank contents are not cleared by reset; EMPTY/FULL state gates their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[wr_ptr][lane] <= bus.s_real;
            mem_im[wr_ptr][lane] <= bus.s_imag;
        end
    end

    always_comb begin
        bus.dout_real = '0;
        bus.dout_imag = '0;
        if (dout_valid_int) begin
            for (int unsigned i = 0; i < N; i++) begin
                bus.dout_real[i*WIDTH +: WIDTH] = mem_re[rd_ptr][i];
                bus.dout_imag[i*WIDTH +: WIDTH] = mem_im[rd_ptr][i];
            end
        end
    end
endmodule
